// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus observer: event classes, the event record
// and the qualification FSM states.
package z80_bus_pkg;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_IO_RD  = 3'd1;
    localparam logic [2:0] EV_IO_WR  = 3'd2;
    localparam logic [2:0] EV_MEM_RD = 3'd3;
    localparam logic [2:0] EV_MEM_WR = 3'd4;
    localparam logic [2:0] EV_FETCH  = 3'd5;
    localparam logic [2:0] EV_INTACK = 3'd6;

    typedef struct packed {
        logic [2:0]  ev_type;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    typedef enum logic [1:0] {StIdle, StQual, StActive} state_e;

    // Strobes are active-low; first matching row wins.
    function automatic logic [2:0] classify(input logic rd, input logic wr, input logic m1,
                                            input logic iorq, input logic mreq);
        logic [2:0] cls;
        cls = EV_NONE;
        if (!iorq && !m1)              cls = EV_INTACK;
        else if (!rd && !wr)           cls = EV_NONE;
        else if (!iorq && !wr)         cls = EV_IO_WR;
        else if (!iorq && !rd)         cls = EV_IO_RD;
        else if (!mreq && !m1 && !rd)  cls = EV_FETCH;
        else if (!mreq && !rd)         cls = EV_MEM_RD;
        else if (!mreq && !wr)         cls = EV_MEM_WR;
        return cls;
    endfunction

endpackage

// File: rtl/z80_event_fifo.sv
// Small synchronous event queue with a registered head entry, so the consumer
// sees flop outputs that only change after a push-to-empty or a pop.
module z80_event_fifo
    import z80_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  ev_t  wdata,
    input  logic pop,
    output logic full,
    output logic empty,
    output ev_t  head
);
    localparam int unsigned AW = $clog2(DEPTH);

    ev_t            mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q, rptr_nxt;
    logic [AW:0]    count_q;
    ev_t            head_q;
    logic           do_push, do_pop;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rptr_nxt = rptr_q + 1'b1;
    assign head     = head_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_nxt;
            count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
            // Head tracks the oldest entry; a drained queue shows zeros.
            if (do_pop) begin
                if (count_q > (AW + 1)'(1)) head_q <= mem_q[rptr_nxt];
                else if (do_push)           head_q <= wdata;
                else                        head_q <= '0;
            end else if (do_push && empty) begin
                head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/z80_bus_sampler.sv
// Synchronises the Z80 pins, classifies each bus cycle, filters glitches and
// queues exactly one event per qualified cycle.
module z80_bus_sampler
    import z80_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] z80_a,
    input  logic [7:0]  z80_d,
    input  logic        z80_rd,
    input  logic        z80_wr,
    input  logic        z80_m1,
    input  logic        z80_iorq,
    input  logic        z80_mreq,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [2:0]  ev_type,
    output logic [15:0] ev_addr,
    output logic [7:0]  ev_data,
    output logic        ev_overflow
);
    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [4:0]  strb_q [SYNC_STAGES];
    logic [15:0] addr_q [SYNC_STAGES];
    logic [7:0]  data_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strb_q[i] <= '1;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            strb_q[0] <= {z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};
            addr_q[0] <= z80_a;
            data_q[0] <= z80_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strb_q[i] <= strb_q[i-1];
                addr_q[i] <= addr_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    logic rd_s, wr_s, m1_s, iorq_s, mreq_s;
    ev_t  cur_ev;

    assign {rd_s, wr_s, m1_s, iorq_s, mreq_s} = strb_q[SYNC_STAGES-1];

    always_comb begin
        cur_ev.ev_type = classify(rd_s, wr_s, m1_s, iorq_s, mreq_s);
        cur_ev.addr    = addr_q[SYNC_STAGES-1];
        cur_ev.data    = ((cur_ev.ev_type == EV_IO_WR) || (cur_ev.ev_type == EV_MEM_WR)) ?
                         data_q[SYNC_STAGES-1] : '0;
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    ev_t              snap_q;
    logic             push_req;

    assign push_req = (state_q == StQual) && (cur_ev.ev_type != EV_NONE) &&
                      (cur_ev == snap_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cur_ev.ev_type != EV_NONE) begin
                        snap_q  <= cur_ev;
                        cnt_q   <= '0;
                        state_q <= StQual;
                    end
                end
                StQual: begin
                    if (cur_ev.ev_type == EV_NONE) begin
                        state_q <= StIdle;
                    end else if (cur_ev != snap_q) begin
                        snap_q <= cur_ev;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= StActive;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StActive: begin
                    // Hold until the strobes drop so one Z80 cycle yields one event.
                    if (cur_ev.ev_type == EV_NONE) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic fifo_full, fifo_empty;
    ev_t  head;

    z80_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (snap_q),
        .pop   (ev_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !ev_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign ev_valid    = !fifo_empty;
    assign ev_type     = head.ev_type;
    assign ev_addr     = head.addr;
    assign ev_data     = head.data;
    assign ev_overflow = ovf_q;

endmodule
